// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor magnitude.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // The shifted partial remainder needs WIDTH+1 bits when the divisor has its MSB set.
  assign w_rem_sh = {rem_in, quo_in[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, dvsr});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - dvsr;
  assign rem_out  = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
  assign quo_out  = {quo_in[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/done handshake, optional signed mode
// and divide-by-zero detection. Results are held until the next accepted start.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg_dvd;
  logic             r_neg_dvs;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_sgn;
  logic             w_neg_dvd;
  logic             w_neg_dvs;
  logic [WIDTH-1:0] w_mag_dvd;
  logic [WIDTH-1:0] w_mag_dvs;
  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  // Magnitudes are taken as unsigned, so a MIN operand maps to 2^(WIDTH-1) exactly.
  assign w_sgn      = SIGNED_EN && signed_op;
  assign w_neg_dvd  = w_sgn && dividend[WIDTH-1];
  assign w_neg_dvs  = w_sgn && divisor[WIDTH-1];
  assign w_mag_dvd  = w_neg_dvd ? -dividend : dividend;
  assign w_mag_dvs  = w_neg_dvs ? -divisor : divisor;
  assign w_dvs_zero = (divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (r_rem),
    .quo_in (r_quo),
    .dvsr   (r_dvsr),
    .rem_out(w_step_rem),
    .quo_out(w_step_quo)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_dvs_zero ? S_DONE : S_CALC;
      S_CALC:  if (r_count == CNT_W'(1)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_neg_dvd   <= 1'b0;
      r_neg_dvs   <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem     <= '0;
            r_quo     <= w_mag_dvd;
            r_dvsr    <= w_mag_dvs;
            r_neg_dvd <= w_neg_dvd;
            r_neg_dvs <= w_neg_dvs;
            r_count   <= CNT_W'(WIDTH);
            if (w_dvs_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_rem   <= w_step_rem;
          r_quo   <= w_step_quo;
          r_count <= r_count - CNT_W'(1);
        end
        S_FIX: begin
          // C truncation: quotient sign from sign mismatch, remainder follows the dividend.
          r_quotient  <= (r_neg_dvd ^ r_neg_dvs) ? -r_quo : r_quo;
          r_remainder <= r_neg_dvd ? -r_rem : r_rem;
          r_dbz       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
